// File: rtl/cmp_pkg.sv
// Shared definitions for the multi-channel comparator: mode encoding and widths.
package cmp_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LT = 3'd2,
    CMP_GT = 3'd3,
    CMP_LE = 3'd4,
    CMP_GE = 3'd5
  } cmp_mode_e;

endpackage

// File: rtl/cmp_multi_if.sv
// Sample/result bus of cmp_multi; master is the producer of samples, slave is the comparator.
interface cmp_multi_if #(
  parameter int DATA_W = 16,
  parameter int CH     = 4,
  parameter int CNT_W  = 8
);
  import cmp_pkg::*;

  // Handshake: in_valid qualifies a/b/mode/sgn for one cycle and is always accepted
  // (no ready, no backpressure); out_valid/agg_valid are single-cycle freshness strobes.
  logic                    in_valid;
  logic [MODE_W-1:0]       mode;
  logic                    sgn;
  logic [CH*DATA_W-1:0]    a;
  logic [CH*DATA_W-1:0]    b;
  logic                    cnt_clr;
  logic                    out_valid;
  logic [CH-1:0]           r;
  logic                    agg_valid;
  logic                    r_any;
  logic                    r_all;
  logic [CH*CNT_W-1:0]     cnt;

  modport master (
    output in_valid, mode, sgn, a, b, cnt_clr,
    input  out_valid, r, agg_valid, r_any, r_all, cnt
  );

  modport slave (
    input  in_valid, mode, sgn, a, b, cnt_clr,
    output out_valid, r, agg_valid, r_any, r_all, cnt
  );

endinterface

// File: rtl/cmp_cell.sv
// One comparator channel: evaluates a OP b under the shared mode and registers the result.
module cmp_cell
  import cmp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              sgn,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              r
);

  // One extra bit lets a single signed compare serve both signed and unsigned modes.
  logic signed [DATA_W:0] a_x;
  logic signed [DATA_W:0] b_x;
  logic                   eq;
  logic                   lt;
  logic                   r_d;
  logic                   r_q;

  assign a_x = {sgn & a[DATA_W-1], a};
  assign b_x = {sgn & b[DATA_W-1], b};
  assign eq  = (a == b);
  assign lt  = (a_x < b_x);

  always_comb begin
    r_d = 1'b0;
    case (mode)
      CMP_EQ:  r_d = eq;
      CMP_NE:  r_d = !eq;
      CMP_LT:  r_d = lt;
      CMP_GT:  r_d = !lt && !eq;
      CMP_LE:  r_d = lt || eq;
      CMP_GE:  r_d = !lt;
      default: r_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (en) begin
      r_q <= r_d;
    end
  end

  assign r = r_q;

endmodule

// File: rtl/cmp_multi.sv
// Multi-channel registered comparator with any/all reduction and saturating per-channel hit counters.
module cmp_multi
  import cmp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CH     = 4,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  cmp_multi_if.slave  bus
);

  logic [CH-1:0]             r_q;
  logic                      out_valid_q;
  logic                      agg_valid_q;
  logic                      r_any_q;
  logic                      r_all_q;
  logic [CH-1:0][CNT_W-1:0]  cnt_q;
  logic [CH-1:0][CNT_W-1:0]  cnt_d;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    cmp_cell #(.DATA_W(DATA_W)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.in_valid),
      .mode (bus.mode),
      .sgn  (bus.sgn),
      .a    (bus.a[i*DATA_W +: DATA_W]),
      .b    (bus.b[i*DATA_W +: DATA_W]),
      .r    (r_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      agg_valid_q <= 1'b0;
      r_any_q     <= 1'b0;
      r_all_q     <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      agg_valid_q <= out_valid_q;
      if (out_valid_q) begin
        r_any_q <= |r_q;
        r_all_q <= &r_q;
      end
    end
  end

  // Clear takes priority, so a hit landing on the clear edge is dropped.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < CH; i++) begin
      if (bus.cnt_clr) begin
        cnt_d[i] = '0;
      end else if (out_valid_q && r_q[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
  assign bus.agg_valid = agg_valid_q;
  assign bus.r_any     = r_any_q;
  assign bus.r_all     = r_all_q;
  assign bus.cnt       = cnt_q;

endmodule

// File: doc/cmp_multi.md
# cmp_multi

Multi-channel, mode-selectable registered comparator; the parametrised successor of the single-channel equality comparator used in the neuro-skin datapath. Compares CH independent operand pairs under one shared mode (eq/ne/lt/gt/le/ge, signed or unsigned) with a valid strobe. Adds any/all reduction flags and per-channel saturating hit counters. Sits between the feature-extraction stage and the classifier threshold logic.

## Interface
- DATA_W, 16, operand width per channel
- CH, 4, number of channels (≥1)
- CNT_W, 8, per-channel hit counter width (≥1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  a/b/mode/sgn qualified this cycle
- mode  in  3  compare mode: 0 eq, 1 ne, 2 lt, 3 gt, 4 le, 5 ge, 6-7 reserved
- sgn  in  1  1 = operands two's-complement signed, 0 = unsigned
- a  in  CH*DATA_W  channel i operand A at bits [i*DATA_W +: DATA_W]
- b  in  CH*DATA_W  channel i operand B, same packing
- cnt_clr  in  1  synchronous clear of all hit counters
- out_valid  out  1  r is fresh this cycle
- r  out  CH  per-channel compare result (a OP b)
- agg_valid  out  1  r_any/r_all fresh this cycle
- r_any  out  1  OR of r for the qualifying sample
- r_all  out  1  AND of r for the qualifying sample
- cnt  out  CH*CNT_W  channel i hit count at bits [i*CNT_W +: CNT_W]

## Operation
- Stage 1: when in_valid=1, r[i] <= (a_i OP b_i) per mode/sgn; out_valid <= in_valid every cycle.
- When in_valid=0, r holds its previous value; only out_valid drops.
- Reserved mode 6/7: every r[i]=0 for that sample (out_valid still asserts).
- sgn=1: comparison on sign-extended operands; eq/ne unaffected by sgn.
- Stage 2: when out_valid=1, r_any <= |r, r_all <= &r; agg_valid <= out_valid. Flags hold when out_valid=0.
- Counters: when out_valid=1 and r[i]=1, cnt_i increments by 1; saturates at 2^CNT_W-1 (no wrap).
- cnt_clr=1 sets all counters to 0 that cycle; clear wins over a coincident increment.
- Reset (async, any time, including mid-stream): r=0, out_valid=0, r_any=0, r_all=0, agg_valid=0, all cnt=0. In-flight samples discarded; first valid output after release follows the first post-reset in_valid.

## Timing
- Input sampled at edge t (in_valid=1) -> r/out_valid at t+1 (latency 1, identical to the original comparator).
- r_any/r_all/agg_valid at t+2.
- cnt reflects sample t at t+2.
- Full throughput: one sample per cycle, back-to-back in_valid supported, no backpressure.
- cnt_clr asserted at edge t -> cnt=0 visible at t+1; a hit whose increment lands at the same edge is lost.

## Structure
- Package cmp_pkg: mode constants (CMP_EQ..CMP_GE), mode width localparam (3).
- Sub-module cmp_cell: one channel, parameter DATA_W; inputs clk, rst, en, mode, sgn, a, b; registered output r. Generated CH times.
- Reduction and counters stay in cmp_multi top.

## Test plan
- DATA_W=16, CH=4: mode=eq, a=b={0x1234×4} except ch2 b=0x1235, in_valid one cycle -> r=4'b1011 at t+1, r_any=1, r_all=0 at t+2.
- Signedness: a=0xFFFF, b=0x0001, mode=lt: sgn=1 -> r=1; sgn=0 -> r=0; mode=eq with either sgn -> r=0.
- All six modes plus mode=6 on a=5, b=5 and a=3, b=7 back-to-back -> r matches truth table every cycle, mode 6 -> 0, no bubbles.
- CNT_W=3: 10 consecutive hits on ch0 -> cnt0 reads 7 and holds; cnt_clr on a hit cycle -> 0, next hit -> 1.
- in_valid gaps: r and r_any/r_all hold last values while out_valid/agg_valid drop.
- Async rst asserted mid-burst between edges -> all outputs 0 immediately; post-release in_valid -> valid outputs at t+1/t+2 only.
